lcd_ctrl: RTL and testbench

//  Downstream consumer of the LSU LCD register (0x1000_4xxx). Takes a command word on a
//  one-cycle write strobe and sequences HD44780-style bus timing: setup, EN pulse, hold,

---
 rtl/lcd_ctrl_if.sv | 23 ++
 rtl/lcd_ctrl.sv | 203 ++++++++++++++++++++
 tb/tb_lcd_ctrl.sv | 289 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/lcd_ctrl_if.sv
// rtl/lcd_ctrl_if.sv - command strobe, HD44780 bus and status bundle for lcd_ctrl
interface lcd_ctrl_if;
   logic [31:0] i_lcd_word;
   logic        i_lcd_wr;
   logic [7:0]  i_lcd_rdata;
   logic [7:0]  o_lcd_data;
   logic        o_lcd_rs;
   logic        o_lcd_rw;
   logic        o_lcd_en;
   logic        o_lcd_on;
   logic        o_busy;
   logic [7:0]  o_rd_data;

   modport master (
      output i_lcd_word, i_lcd_wr, i_lcd_rdata,
      input  o_lcd_data, o_lcd_rs, o_lcd_rw, o_lcd_en, o_lcd_on, o_busy, o_rd_data
   );

   modport slave (
      input  i_lcd_word, i_lcd_wr, i_lcd_rdata,
      output o_lcd_data, o_lcd_rs, o_lcd_rw, o_lcd_en, o_lcd_on, o_busy, o_rd_data
   );
endinterface

// File: rtl/lcd_ctrl.sv
// rtl/lcd_ctrl.sv - HD44780 bus sequencer with one-deep pending buffer; LCD_INIT_EN adds power-on init
module lcd_ctrl #(
   parameter int SETUP_CYC     = 3,
   parameter int PW_CYC        = 12,
   parameter int HOLD_CYC      = 2,
   parameter int EXEC_CYC      = 2000,
   parameter int EXEC_LONG_CYC = 80000
) (
   input  logic      i_clk,
   input  logic      i_reset,
   lcd_ctrl_if.slave bus
);
   function automatic int imax(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

`ifdef LCD_INIT_EN
   localparam int INIT_WAIT_CYC = EXEC_LONG_CYC * 10;
`else
   localparam int INIT_WAIT_CYC = 0;
`endif
   localparam int MAX_CYC = imax(imax(imax(SETUP_CYC, PW_CYC), imax(HOLD_CYC, EXEC_CYC)),
                                 imax(EXEC_LONG_CYC, INIT_WAIT_CYC));
   localparam int CW = $clog2(MAX_CYC + 1);

   localparam logic [CW-1:0] SETUP_LAST     = CW'(SETUP_CYC - 1);
   localparam logic [CW-1:0] PW_LAST        = CW'(PW_CYC - 1);
   localparam logic [CW-1:0] HOLD_LAST      = CW'(HOLD_CYC - 1);
   localparam logic [CW-1:0] EXEC_LAST      = CW'(EXEC_CYC - 1);
   localparam logic [CW-1:0] EXEC_LONG_LAST = CW'(EXEC_LONG_CYC - 1);

   typedef enum logic [2:0] {
      IDLE, SETUP, PULSE, HOLD, EXEC
`ifdef LCD_INIT_EN
      , INIT_WAIT
`endif
   } state_t;

   state_t        state;
   logic [CW-1:0] cnt;
   logic          pend_full;
   logic [10:0]   pend_word;
   logic [7:0]    data_q;
   logic [7:0]    rd_q;
   logic          rs_q, rw_q, en_q, on_q;
   logic [10:0]   wr_word;
   logic          exec_long;
   logic [CW-1:0] exec_last;
   logic          idle_free;
   logic          drain;
   logic          wr_to_pend;

   // Packed as {on, rs, rw, data}; remaining command bits are don't-care.
   assign wr_word = {bus.i_lcd_word[31], bus.i_lcd_word[9:0]};
   wire unused_word_bits = ^bus.i_lcd_word[30:10];

   // Clear display and return home (0x01..0x03) need the long execution wait.
   assign exec_long = !rs_q && !rw_q && (data_q == 8'h01 || data_q == 8'h02 || data_q == 8'h03);
   assign exec_last = exec_long ? EXEC_LONG_LAST : EXEC_LAST;

`ifdef LCD_INIT_EN
   localparam logic [CW-1:0] INIT_LAST = CW'(INIT_WAIT_CYC - 1);

   logic       init_run;
   logic [2:0] init_idx;

   function automatic logic [7:0] init_byte(input logic [2:0] idx);
      case (idx)
         3'd0, 3'd1, 3'd2: init_byte = 8'h38;
         3'd3:             init_byte = 8'h0C;
         3'd4:             init_byte = 8'h01;
         default:          init_byte = 8'h06;
      endcase
   endfunction

   assign idle_free = !pend_full && !init_run;
   assign drain     = (state == IDLE) && pend_full && !init_run;
`else
   assign idle_free = !pend_full;
   assign drain     = (state == IDLE) && pend_full;
`endif

   // Strobes that cannot go straight onto the bus land in the pending slot.
   assign wr_to_pend = bus.i_lcd_wr && !((state == IDLE) && idle_free);

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         state     <= IDLE;
         cnt       <= '0;
         pend_full <= 1'b0;
         pend_word <= '0;
         data_q    <= '0;
         rs_q      <= 1'b0;
         rw_q      <= 1'b0;
         en_q      <= 1'b0;
         on_q      <= 1'b0;
         rd_q      <= '0;
`ifdef LCD_INIT_EN
         init_run  <= 1'b1;
         init_idx  <= '0;
`endif
      end else begin
         case (state)
            IDLE: begin
`ifdef LCD_INIT_EN
               if (init_run) begin
                  state <= INIT_WAIT;
                  cnt   <= '0;
                  on_q  <= 1'b1;
               end else
`endif
               if (pend_full) begin
                  {on_q, rs_q, rw_q, data_q} <= pend_word;
                  cnt   <= '0;
                  state <= SETUP;
               end else if (bus.i_lcd_wr) begin
                  {on_q, rs_q, rw_q, data_q} <= wr_word;
                  cnt   <= '0;
                  state <= SETUP;
               end
            end
            SETUP: begin
               if (cnt == SETUP_LAST) begin
                  cnt   <= '0;
                  en_q  <= 1'b1;
                  state <= PULSE;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            PULSE: begin
               if (cnt == PW_LAST) begin
                  cnt   <= '0;
                  en_q  <= 1'b0;
                  state <= HOLD;
                  if (rw_q) begin
                     rd_q <= bus.i_lcd_rdata;
                  end
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            HOLD: begin
               if (cnt == HOLD_LAST) begin
                  cnt   <= '0;
                  state <= EXEC;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            EXEC: begin
               if (cnt == exec_last) begin
                  cnt   <= '0;
                  state <= IDLE;
`ifdef LCD_INIT_EN
                  if (init_run) begin
                     if (init_idx == 3'd6) begin
                        init_run <= 1'b0;
                     end else begin
                        {rs_q, rw_q} <= 2'b00;
                        data_q       <= init_byte(init_idx);
                        init_idx     <= init_idx + 3'd1;
                        state        <= SETUP;
                     end
                  end
`endif
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
`ifdef LCD_INIT_EN
            INIT_WAIT: begin
               if (cnt == INIT_LAST) begin
                  cnt          <= '0;
                  {rs_q, rw_q} <= 2'b00;
                  data_q       <= init_byte(3'd0);
                  init_idx     <= 3'd1;
                  state        <= SETUP;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
`endif
            default: state <= IDLE;
         endcase

         if (wr_to_pend) begin
            pend_word <= wr_word;
            pend_full <= 1'b1;
         end else if (drain) begin
            pend_full <= 1'b0;
         end
      end
   end

   assign bus.o_lcd_data = data_q;
   assign bus.o_lcd_rs   = rs_q;
   assign bus.o_lcd_rw   = rw_q;
   assign bus.o_lcd_en   = en_q;
   assign bus.o_lcd_on   = on_q;
   assign bus.o_rd_data  = rd_q;
   assign bus.o_busy     = (state != IDLE) | pend_full;
endmodule

// File: tb/tb_lcd_ctrl.sv
// tb/tb_lcd_ctrl.sv - directed bench for lcd_ctrl with shortened bus timing
`timescale 1ns/1ps
module tb_lcd_ctrl;
   localparam int SETUP = 3, PW = 12, HOLD = 2, EXEC = 20, EXEC_LONG = 100;

   logic clk   = 1'b0;
   logic reset = 1'b1;
   int   n_vec  = 0;
   int   n_miss = 0;
   logic [7:0] en_data[$];
   logic en_d = 1'b0;

   lcd_ctrl_if bus ();

   lcd_ctrl #(
      .SETUP_CYC(SETUP), .PW_CYC(PW), .HOLD_CYC(HOLD),
      .EXEC_CYC(EXEC), .EXEC_LONG_CYC(EXEC_LONG)
   ) dut (
      .i_clk(clk),
      .i_reset(reset),
      .bus(bus)
   );

   always #5 clk = ~clk;

   // Byte on the bus at every EN rising edge.
   always @(negedge clk) begin
      if (bus.o_lcd_en && !en_d) en_data.push_back(bus.o_lcd_data);
      en_d = bus.o_lcd_en;
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic run_word(input logic [31:0] w, output int rise, output int fall, output int done);
      rise = -1; fall = -1; done = -1;
      bus.i_lcd_word = w;
      bus.i_lcd_wr   = 1'b1;
      step();
      bus.i_lcd_wr = 1'b0;
      for (int c = 1; c <= 400; c++) begin
         if (bus.o_lcd_en && rise < 0) rise = c;
         if (!bus.o_lcd_en && rise >= 0 && fall < 0) fall = c;
         if (!bus.o_busy) begin
            done = c;
            break;
         end
         step();
      end
   endtask

   task automatic test_reset();
      logic [20:0] outs;
      reset = 1'b1;
      repeat (3) step();
      outs = {bus.o_lcd_en, bus.o_lcd_rs, bus.o_lcd_rw, bus.o_lcd_on, bus.o_busy,
              bus.o_lcd_data, bus.o_rd_data};
      n_vec++;
      if (outs !== 21'd0) begin
         n_miss++; $display("FAIL reset_outputs: got %h want 0", outs);
      end
      reset = 1'b0;
      n_vec++;
      if (bus.o_busy !== 1'b0) begin
         n_miss++; $display("FAIL reset_busy: got %b want 0", bus.o_busy);
      end
   endtask

`ifdef LCD_INIT_EN
   task automatic test_init();
      logic [7:0] exp_b[6] = '{8'h38, 8'h38, 8'h38, 8'h0C, 8'h01, 8'h06};
      int done = -1;
      int rise = -1;
      en_data.delete();
      for (int c = 1; c <= 2000; c++) begin
         step();
         if (bus.o_lcd_en && rise < 0) rise = c;
         if (!bus.o_busy) begin
            done = c;
            break;
         end
      end
      n_vec++;
      if (rise !== 1004) begin
         n_miss++; $display("FAIL init_first_en: got %0d want 1004", rise);
      end
      n_vec++;
      if (done !== 1303) begin
         n_miss++; $display("FAIL init_done: got %0d want 1303", done);
      end
      n_vec++;
      if (en_data.size() !== 6) begin
         n_miss++; $display("FAIL init_count: got %0d want 6", en_data.size());
      end else begin
         for (int i = 0; i < 6; i++) begin
            n_vec++;
            if (en_data[i] !== exp_b[i]) begin
               n_miss++; $display("FAIL init_byte%0d: got %h want %h", i, en_data[i], exp_b[i]);
            end
         end
      end
      n_vec++;
      if (bus.o_lcd_on !== 1'b1) begin
         n_miss++; $display("FAIL init_on: got %b want 1", bus.o_lcd_on);
      end
   endtask
`endif

   task automatic test_single();
      int r, f, d;
      logic [10:0] bus_v;
      en_data.delete();
      run_word(32'h8000_0241, r, f, d);
      n_vec++;
      if (r !== 4) begin n_miss++; $display("FAIL single_en_rise: got %0d want 4", r); end
      n_vec++;
      if (f !== 16) begin n_miss++; $display("FAIL single_en_fall: got %0d want 16", f); end
      n_vec++;
      if (d !== 38) begin n_miss++; $display("FAIL single_busy_low: got %0d want 38", d); end
      bus_v = {bus.o_lcd_on, bus.o_lcd_rs, bus.o_lcd_rw, bus.o_lcd_data};
      n_vec++;
      if (bus_v !== 11'b1_1_0_0100_0001) begin
         n_miss++; $display("FAIL single_bus: got %b want 11001000001", bus_v);
      end
      n_vec++;
      if (en_data.size() !== 1 || en_data[0] !== 8'h41) begin
         n_miss++; $display("FAIL single_en_data: got n=%0d want one 41", en_data.size());
      end
   endtask

   task automatic test_exec_len();
      logic [31:0] words[7] = '{32'h0000_0001, 32'h0000_0003, 32'h0000_0002, 32'h0000_0004,
                                32'h0000_0080, 32'h0000_0201, 32'h0000_0101};
      int exp_d[7] = '{118, 118, 118, 38, 38, 38, 38};
      int r, f, d;
      bus.i_lcd_rdata = 8'h00;
      for (int i = 0; i < 7; i++) begin
         run_word(words[i], r, f, d);
         n_vec++;
         if (d !== exp_d[i]) begin
            n_miss++; $display("FAIL exec_len_%h: got %0d want %0d", words[i], d, exp_d[i]);
         end
      end
   endtask

   task automatic test_back_to_back();
      int done = -1;
      en_data.delete();
      bus.i_lcd_word = 32'h8000_0241;
      bus.i_lcd_wr   = 1'b1;
      step();
      for (int c = 1; c <= 600; c++) begin
         bus.i_lcd_wr = 1'b0;
         if (!bus.o_busy) begin
            done = c;
            break;
         end
         if (c == 5) begin
            bus.i_lcd_word = 32'h8000_0242; bus.i_lcd_wr = 1'b1;
         end else if (c == 7) begin
            bus.i_lcd_word = 32'h8000_0243; bus.i_lcd_wr = 1'b1;
         end else if (c == 38) begin
            bus.i_lcd_word = 32'h8000_0244; bus.i_lcd_wr = 1'b1;
         end
         step();
      end
      bus.i_lcd_wr = 1'b0;
      n_vec++;
      if (done !== 114) begin n_miss++; $display("FAIL b2b_busy_low: got %0d want 114", done); end
      n_vec++;
      if (en_data.size() !== 3) begin
         n_miss++; $display("FAIL b2b_count: got %0d want 3", en_data.size());
      end else begin
         n_vec++;
         if ({en_data[0], en_data[1], en_data[2]} !== 24'h414344) begin
            n_miss++;
            $display("FAIL b2b_order: got %h%h%h want 414344", en_data[0], en_data[1], en_data[2]);
         end
      end
   endtask

   task automatic test_read();
      int done = -1;
      bus.i_lcd_rdata = 8'h5A;
      bus.i_lcd_word  = 32'h0000_0100;
      bus.i_lcd_wr    = 1'b1;
      step();
      bus.i_lcd_wr = 1'b0;
      for (int c = 1; c <= 400; c++) begin
         if (c == 1) begin
            n_vec++;
            if ({bus.o_lcd_rs, bus.o_lcd_rw} !== 2'b01) begin
               n_miss++; $display("FAIL read_rsrw: got %b want 01", {bus.o_lcd_rs, bus.o_lcd_rw});
            end
         end
         if (c == 15) begin
            n_vec++;
            if (bus.o_rd_data !== 8'h00) begin
               n_miss++; $display("FAIL read_early: got %h want 00", bus.o_rd_data);
            end
         end
         if (c == 16) begin
            n_vec++;
            if (bus.o_rd_data !== 8'h5A) begin
               n_miss++; $display("FAIL read_capture: got %h want 5A", bus.o_rd_data);
            end
         end
         if (!bus.o_busy) begin
            done = c;
            break;
         end
         step();
      end
      bus.i_lcd_rdata = 8'h11;
      repeat (3) step();
      n_vec++;
      if (done !== 38 || bus.o_rd_data !== 8'h5A) begin
         n_miss++; $display("FAIL read_hold: got done=%0d rd=%h want 38/5A", done, bus.o_rd_data);
      end
   endtask

   task automatic test_reset_mid();
      logic [12:0] outs;
      int r, f, d;
      bus.i_lcd_word = 32'h8000_0241;
      bus.i_lcd_wr   = 1'b1;
      step();
      for (int c = 1; c <= 8; c++) begin
         bus.i_lcd_wr = 1'b0;
         if (c == 6) begin
            bus.i_lcd_word = 32'h8000_0242; bus.i_lcd_wr = 1'b1;
         end
         if (c == 8) reset = 1'b1;
         step();
      end
      reset = 1'b0;
      outs = {bus.o_lcd_en, bus.o_busy, bus.o_lcd_on, bus.o_lcd_rs, bus.o_lcd_rw, bus.o_lcd_data};
      n_vec++;
      if (outs !== 13'd0) begin
         n_miss++; $display("FAIL reset_mid_outputs: got %b want 0", outs);
      end
      n_vec++;
      if (bus.o_rd_data !== 8'h00) begin
         n_miss++; $display("FAIL reset_mid_rd: got %h want 00", bus.o_rd_data);
      end
      en_data.delete();
      repeat (30) step();
      n_vec++;
      if (en_data.size() !== 0) begin
         n_miss++; $display("FAIL reset_mid_lost: got %0d EN pulses want 0", en_data.size());
      end
`ifdef LCD_INIT_EN
      for (int c = 0; c < 2000 && bus.o_busy; c++) step();
      en_data.delete();
`endif
      n_vec++;
      if (bus.o_busy !== 1'b0) begin
         n_miss++; $display("FAIL reset_mid_idle: got busy=%b want 0", bus.o_busy);
      end
      run_word(32'h8000_0255, r, f, d);
      n_vec++;
      if (r !== 4 || f !== 16 || d !== 38) begin
         n_miss++; $display("FAIL reset_mid_after: got %0d/%0d/%0d want 4/16/38", r, f, d);
      end
      n_vec++;
      if (en_data.size() !== 1 || en_data[0] !== 8'h55) begin
         n_miss++; $display("FAIL reset_mid_data: got n=%0d want one 55", en_data.size());
      end
   endtask

   initial begin
      bus.i_lcd_word  = 32'h0;
      bus.i_lcd_wr    = 1'b0;
      bus.i_lcd_rdata = 8'h00;
      test_reset();
`ifdef LCD_INIT_EN
      test_init();
`endif
      test_single();
      test_exec_len();
      test_back_to_back();
      test_read();
      test_reset_mid();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end
endmodule
